// File: rtl/int_ctrl_if.sv
// rtl/int_ctrl_if.sv - register bus bundle between a bus master and int_ctrl
// Ports (master view):
//   data_i  out 32  write data
//   addr_i  out 32  register address
//   we_i    out 1   write strobe
//   re_i    out 1   read strobe
//   data_o  in  32  read data, combinational from addr_i
interface int_ctrl_if;
   logic [31:0] data_i;
   logic [31:0] addr_i;
   logic        we_i;
   logic        re_i;
   logic [31:0] data_o;

   modport master (output data_i, output addr_i, output we_i, output re_i, input data_o);
   modport slave  (input data_i, input addr_i, input we_i, input re_i, output data_o);
endinterface

// File: rtl/int_ctrl.sv
// rtl/int_ctrl.sv - interrupt controller with pending latch, fixed priority and claim/complete
// Ports:
//   clk        in  1      clock
//   rst_n      in  1      synchronous active-low reset
//   bus        slave      register bus (ENABLE 0x0, PENDING 0x4, CLAIM 0x8, MODE 0xC)
//   irq_src_i  in  N_SRC  peripheral interrupt lines, active-high
//   int_req_o  out 1      aggregated request to the core
module int_ctrl #(
   parameter int N_SRC = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   int_ctrl_if.slave        bus,
   input  logic [N_SRC-1:0] irq_src_i,
   output logic             int_req_o
);

   localparam logic [3:0] A_ENABLE  = 4'h0;
   localparam logic [3:0] A_PENDING = 4'h4;
   localparam logic [3:0] A_CLAIM   = 4'h8;
   localparam logic [3:0] A_MODE    = 4'hC;
   localparam int         PAD       = 32 - N_SRC;

   typedef enum logic {S_IDLE, S_CLAIMED} state_t;

   state_t           state_q, state_d;
   logic [4:0]       claimed_id_q, claimed_id_d;
   logic [4:0]       winner_id;
   logic [N_SRC-1:0] enable_q, pending_q, mode_q, src_q;
   logic [N_SRC-1:0] pending_d, claim_clr, level_blk, set_edge, set_level;
   logic [3:0]       addr;
   logic             claim_fire, complete_fire;
   logic             unused_bits;

   assign addr        = bus.addr_i[3:0];
   assign unused_bits = ^{bus.addr_i[31:4], bus.data_i[31:N_SRC]};

   // Lowest index wins: scan from the top so the last hit is the lowest.
   always_comb begin
      winner_id = '0;
      for (int i = N_SRC - 1; i >= 0; i--) begin
         if (pending_q[i] && enable_q[i]) winner_id = 5'(i + 1);
      end
   end

   assign claim_fire    = bus.re_i && !bus.we_i && (addr == A_CLAIM) &&
                          (state_q == S_IDLE) && (winner_id != 5'd0);
   assign complete_fire = bus.we_i && (addr == A_CLAIM) &&
                          (state_q == S_CLAIMED) && (bus.data_i[4:0] == claimed_id_q);

   // A level source is gated while it is in service, including the claim edge
   // itself; otherwise a source that drops before completion would still leave
   // a stale pending bit behind.
   always_comb begin
      claim_clr = '0;
      level_blk = '0;
      for (int i = 0; i < N_SRC; i++) begin
         claim_clr[i] = claim_fire && (winner_id == 5'(i + 1));
         level_blk[i] = claim_clr[i] ||
                        ((state_q == S_CLAIMED) && (claimed_id_q == 5'(i + 1)));
      end
   end

   assign set_edge  = mode_q & irq_src_i & ~src_q;
   assign set_level = ~mode_q & irq_src_i & ~level_blk;
   // Set is applied after clear so a new edge on the claim edge is not lost.
   assign pending_d = (pending_q & ~claim_clr) | set_edge | set_level;

   always_comb begin
      state_d      = state_q;
      claimed_id_d = claimed_id_q;
      case (state_q)
         S_IDLE: begin
            if (claim_fire) begin
               state_d      = S_CLAIMED;
               claimed_id_d = winner_id;
            end
         end
         S_CLAIMED: begin
            if (complete_fire) begin
               state_d      = S_IDLE;
               claimed_id_d = '0;
            end
         end
         default: begin
            state_d      = S_IDLE;
            claimed_id_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         claimed_id_q <= '0;
         enable_q     <= '0;
         pending_q    <= '0;
         mode_q       <= '0;
         src_q        <= '0;
      end else begin
         state_q      <= state_d;
         claimed_id_q <= claimed_id_d;
         pending_q    <= pending_d;
         src_q        <= irq_src_i;
         if (bus.we_i && (addr == A_ENABLE)) enable_q <= bus.data_i[N_SRC-1:0];
         if (bus.we_i && (addr == A_MODE))   mode_q   <= bus.data_i[N_SRC-1:0];
      end
   end

   assign int_req_o = (state_q == S_IDLE) && (winner_id != 5'd0);

   always_comb begin
      bus.data_o = '0;
      if (rst_n) begin
         case (addr)
            A_ENABLE:  bus.data_o = {{PAD{1'b0}}, enable_q};
            A_PENDING: bus.data_o = {{PAD{1'b0}}, pending_q};
            A_CLAIM:   bus.data_o = (state_q == S_IDLE) ? {27'd0, winner_id} : 32'd0;
            A_MODE:    bus.data_o = {{PAD{1'b0}}, mode_q};
            default:   bus.data_o = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_int_ctrl.sv
// tb/tb_int_ctrl.sv - self-checking bench for int_ctrl with directed and randomized scenarios
module tb_int_ctrl;
   localparam int N    = 8;
   localparam int MASK = (1 << N) - 1;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [N-1:0] irq;
   logic         int_req;
   int           total = 0;
   int           bad   = 0;

   int_ctrl_if bus();

   int_ctrl #(.N_SRC(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .irq_src_i (irq),
      .int_req_o (int_req)
   );

   always #5 clk = ~clk;

   // Reference model: the in-service ID (0 = nothing claimed) stands in for the FSM.
   int m_en, m_mode, m_pend, m_prev, m_claimed;

   function automatic int m_winner();
      for (int i = 0; i < N; i++)
         if ((((m_pend & m_en) >> i) & 1) != 0) return i + 1;
      return 0;
   endfunction

   function automatic int m_read(input logic [31:0] a);
      if (!rst_n) return 0;
      case (a[3:0])
         4'h0:    return m_en;
         4'h4:    return m_pend;
         4'h8:    return (m_claimed == 0) ? m_winner() : 0;
         4'hC:    return m_mode;
         default: return 0;
      endcase
   endfunction

   function automatic bit m_req();
      return (m_claimed == 0) && (m_winner() != 0);
   endfunction

   task automatic model_step();
      int  w, a, np;
      bit  claim, compl, s, p;
      if (!rst_n) begin
         m_en = 0; m_mode = 0; m_pend = 0; m_prev = 0; m_claimed = 0;
         return;
      end
      w     = m_winner();
      a     = int'(bus.addr_i[3:0]);
      claim = bus.re_i && !bus.we_i && a == 8 && m_claimed == 0 && w != 0;
      compl = bus.we_i && a == 8 && m_claimed != 0 && int'(bus.data_i[4:0]) == m_claimed;
      np    = m_pend;
      if (claim) np = np & ~(1 << (w - 1));
      for (int i = 0; i < N; i++) begin
         s = irq[i];
         p = ((m_prev >> i) & 1) != 0;
         if (((m_mode >> i) & 1) != 0) begin
            if (s && !p) np = np | (1 << i);
         end else if (s && m_claimed != i + 1 && !(claim && w == i + 1)) begin
            np = np | (1 << i);
         end
      end
      if (bus.we_i && a == 0)  m_en   = int'(bus.data_i) & MASK;
      if (bus.we_i && a == 12) m_mode = int'(bus.data_i) & MASK;
      if (claim)      m_claimed = w;
      else if (compl) m_claimed = 0;
      m_prev = int'(irq);
      m_pend = np;
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic drive(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
      bus.we_i   = w;
      bus.re_i   = r;
      bus.addr_i = a;
      bus.data_i = d;
      #1;
   endtask

   task automatic step();
      tick();
      drive(1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      drive(1'b1, 1'b0, a, d);
      step();
   endtask

   task automatic pulse(input logic [N-1:0] bits);
      irq = bits;
      drive(1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      irq = '0;
   endtask

   task automatic test_reset();
      logic [31:0] offs [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
      rst_n = 1'b0;
      irq   = '0;
      drive(1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      tick();
      for (int k = 0; k < 4; k++) begin
         drive(1'b0, 1'b1, offs[k], 32'h0);
         total++; if (bus.data_o !== 32'h0) begin bad++; $display("FAIL rst_low_read[%0d] got=%h want=0", k, bus.data_o); end
      end
      total++; if (int_req !== 1'b0) begin bad++; $display("FAIL rst_int_req got=%b want=0", int_req); end
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         drive(1'b0, 1'b1, offs[k], 32'h0);
         total++; if (bus.data_o !== 32'h0) begin bad++; $display("FAIL rst_read[%0d] got=%h want=0", k, bus.data_o); end
      end
      drive(1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   task automatic test_single_edge();
      wr(32'h0, 32'h1);
      wr(32'hC, 32'h1);
      pulse(8'h01);
      drive(1'b0, 1'b0, 32'h4, 32'h0);
      total++; if (bus.data_o !== 32'h1) begin bad++; $display("FAIL se_pending got=%h want=1", bus.data_o); end
      total++; if (int_req !== 1'b1) begin bad++; $display("FAIL se_req got=%b want=1", int_req); end
      drive(1'b0, 1'b1, 32'h8, 32'h0);
      total++; if (bus.data_o !== 32'd1) begin bad++; $display("FAIL se_claim got=%0d want=1", bus.data_o); end
      step();
      drive(1'b0, 1'b0, 32'h4, 32'h0);
      total++; if (bus.data_o !== 32'h0) begin bad++; $display("FAIL se_pending_after got=%h want=0", bus.data_o); end
      total++; if (int_req !== 1'b0) begin bad++; $display("FAIL se_req_after got=%b want=0", int_req); end
      drive(1'b0, 1'b1, 32'h8, 32'h0);
      total++; if (bus.data_o !== 32'd0) begin bad++; $display("FAIL se_claim2 got=%0d want=0", bus.data_o); end
      step();
      wr(32'h8, 32'h1);
   endtask

   task automatic test_priority();
      wr(32'h0, 32'hFF);
      wr(32'hC, 32'hFF);
      pulse(8'h24);
      drive(1'b0, 1'b1, 32'h8, 32'h0);
      total++; if (bus.data_o !== 32'd3) begin bad++; $display("FAIL pr_claim_a got=%0d want=3", bus.data_o); end
      step();
      total++; if (int_req !== 1'b0) begin bad++; $display("FAIL pr_req_claimed got=%b want=0", int_req); end
      wr(32'h8, 32'h3);
      total++; if (int_req !== 1'b1) begin bad++; $display("FAIL pr_req_rerequest got=%b want=1", int_req); end
      drive(1'b0, 1'b1, 32'h8, 32'h0);
      total++; if (bus.data_o !== 32'd6) begin bad++; $display("FAIL pr_claim_b got=%0d want=6", bus.data_o); end
      step();
      wr(32'h8, 32'h6);
      total++; if (int_req !== 1'b0) begin bad++; $display("FAIL pr_req_done got=%b want=0", int_req); end
   endtask

   task automatic test_level();
      wr(32'hC, 32'hFE);
      irq = 8'h01;
      step();
      total++; if (int_req !== 1'b1) begin bad++; $display("FAIL lv_req got=%b want=1", int_req); end
      drive(1'b0, 1'b1, 32'h8, 32'h0);
      total++; if (bus.data_o !== 32'd1) begin bad++; $display("FAIL lv_claim got=%0d want=1", bus.data_o); end
      step();
      step();
      total++; if (int_req !== 1'b0) begin bad++; $display("FAIL lv_req_claimed got=%b want=0", int_req); end
      wr(32'h8, 32'h1);
      total++; if (int_req !== 1'b0) begin bad++; $display("FAIL lv_req_at_complete got=%b want=0", int_req); end
      step();
      total++; if (int_req !== 1'b1) begin bad++; $display("FAIL lv_req_repend got=%b want=1", int_req); end
      drive(1'b0, 1'b1, 32'h8, 32'h0);
      total++; if (bus.data_o !== 32'd1) begin bad++; $display("FAIL lv_claim2 got=%0d want=1", bus.data_o); end
      step();
      irq = '0;
      step();
      wr(32'h8, 32'h1);
      step();
      total++; if (int_req !== 1'b0) begin bad++; $display("FAIL lv_no_rerequest got=%b want=0", int_req); end
   endtask

   task automatic test_wrong_id();
      wr(32'hC, 32'h01);
      pulse(8'h01);
      drive(1'b0, 1'b1, 32'h8, 32'h0);
      total++; if (bus.data_o !== 32'd1) begin bad++; $display("FAIL wid_claim got=%0d want=1", bus.data_o); end
      step();
      wr(32'h8, 32'h2);
      total++; if (int_req !== 1'b0) begin bad++; $display("FAIL wid_req got=%b want=0", int_req); end
      pulse(8'h01);
      drive(1'b0, 1'b1, 32'h8, 32'h0);
      total++; if (bus.data_o !== 32'd0) begin bad++; $display("FAIL wid_claim_blocked got=%0d want=0", bus.data_o); end
      step();
      wr(32'h8, 32'h1);
      total++; if (int_req !== 1'b1) begin bad++; $display("FAIL wid_idle_req got=%b want=1", int_req); end
      drive(1'b0, 1'b1, 32'h8, 32'h0);
      step();
      wr(32'h8, 32'h1);
   endtask

   task automatic test_coincident();
      pulse(8'h01);
      step();
      irq = 8'h01;
      drive(1'b0, 1'b1, 32'h8, 32'h0);
      total++; if (bus.data_o !== 32'd1) begin bad++; $display("FAIL co_claim got=%0d want=1", bus.data_o); end
      step();
      irq = '0;
      drive(1'b0, 1'b0, 32'h4, 32'h0);
      total++; if (bus.data_o !== 32'h1) begin bad++; $display("FAIL co_pending got=%h want=1", bus.data_o); end
      wr(32'h8, 32'h1);
      total++; if (int_req !== 1'b1) begin bad++; $display("FAIL co_req got=%b want=1", int_req); end
      drive(1'b0, 1'b1, 32'h8, 32'h0);
      total++; if (bus.data_o !== 32'd1) begin bad++; $display("FAIL co_claim2 got=%0d want=1", bus.data_o); end
      step();
      wr(32'h8, 32'h1);
   endtask

   task automatic test_enable_mask();
      wr(32'hC, 32'hFF);
      pulse(8'h10);
      wr(32'h0, 32'hEF);
      total++; if (int_req !== 1'b0) begin bad++; $display("FAIL en_masked_req got=%b want=0", int_req); end
      drive(1'b0, 1'b0, 32'h4, 32'h0);
      total++; if (bus.data_o !== 32'h10) begin bad++; $display("FAIL en_kept_pending got=%h want=10", bus.data_o); end
      wr(32'h0, 32'hFF);
      total++; if (int_req !== 1'b1) begin bad++; $display("FAIL en_restored_req got=%b want=1", int_req); end
   endtask

   task automatic test_reset_claimed();
      wr(32'hC, 32'hFF);
      pulse(8'h0D);
      drive(1'b0, 1'b1, 32'h8, 32'h0);
      total++; if (bus.data_o !== 32'd1) begin bad++; $display("FAIL rc_claim got=%0d want=1", bus.data_o); end
      step();
      drive(1'b0, 1'b0, 32'h4, 32'h0);
      total++; if (bus.data_o !== 32'h1C) begin bad++; $display("FAIL rc_pending got=%h want=1c", bus.data_o); end
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      drive(1'b0, 1'b0, 32'h0, 32'h0);
      total++; if (bus.data_o !== 32'h0) begin bad++; $display("FAIL rc_enable got=%h want=0", bus.data_o); end
      drive(1'b0, 1'b0, 32'h4, 32'h0);
      total++; if (bus.data_o !== 32'h0) begin bad++; $display("FAIL rc_pending_after got=%h want=0", bus.data_o); end
      drive(1'b0, 1'b0, 32'hC, 32'h0);
      total++; if (bus.data_o !== 32'h0) begin bad++; $display("FAIL rc_mode got=%h want=0", bus.data_o); end
      total++; if (int_req !== 1'b0) begin bad++; $display("FAIL rc_req got=%b want=0", int_req); end
      drive(1'b0, 1'b1, 32'h8, 32'h0);
      total++; if (bus.data_o !== 32'd0) begin bad++; $display("FAIL rc_claim_after got=%0d want=0", bus.data_o); end
      step();
   endtask

   task automatic test_random();
      logic [31:0] r32;
      logic [31:0] d;
      logic [3:0]  nib;
      int          op;
      for (int c = 0; c < 600; c++) begin
         irq   = irq ^ (N'($urandom) & N'($urandom) & N'($urandom));
         rst_n = ($urandom_range(0, 199) != 0);
         r32   = $urandom;
         d     = $urandom;
         op    = $urandom_range(0, 9);
         case (op)
            0: drive(1'b1, 1'b0, {r32[31:4], 4'h0}, d);
            1: drive(1'b1, 1'b0, {r32[31:4], 4'hC}, d);
            2, 3, 4: begin
               if ($urandom_range(0, 3) != 0) d[4:0] = 5'(m_claimed);
               drive(1'b1, 1'b0, {r32[31:4], 4'h8}, d);
            end
            5, 6, 7: drive(1'b0, 1'b1, {r32[31:4], 4'h8}, d);
            8: begin
               nib = 4'($urandom);
               drive(1'($urandom), 1'b1, {r32[31:4], nib}, d);
            end
            default: drive(1'b1, 1'b1, {r32[31:4], 4'h8}, {d[31:5], 5'(m_claimed)});
         endcase
         total++;
         if (bus.data_o !== m_read(bus.addr_i)) begin
            bad++; $display("FAIL rnd_data[%0d] got=%h want=%h", c, bus.data_o, m_read(bus.addr_i));
         end
         if (rst_n) begin
            total++;
            if (int_req !== m_req()) begin
               bad++; $display("FAIL rnd_req[%0d] got=%b want=%b", c, int_req, m_req());
            end
         end
         tick();
      end
      rst_n = 1'b1;
      drive(1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   initial begin
      rst_n = 1'b0;
      irq   = '0;
      m_en = 0; m_mode = 0; m_pend = 0; m_prev = 0; m_claimed = 0;
      drive(1'b0, 1'b0, 32'h0, 32'h0);
      test_reset();
      test_single_edge();
      test_priority();
      test_level();
      test_wrong_id();
      test_coincident();
      test_enable_mask();
      test_reset_claimed();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/int_ctrl.md
# int_ctrl

Interrupt controller that receives interrupt lines from peripherals such as timer and uart, including the timer's `int_sig_o`. It latches each line into a pending register and presents one aggregated request to the core. It resolves priority with a fixed lowest-index-wins rule and runs a claim/complete handshake over the same simple peripheral register bus the other perips use. It sits between the peripheral interrupt outputs and the core's external-interrupt input.

## Interface
- `N_SRC`, default 8: number of interrupt sources, legal range 1..31. Source i has ID i+1; ID 0 means "none".
- `clk`  in  1  clock
- `rst_n`  in  1  reset, synchronous, active-low; clock clk
- `data_i`  in  32  write data
- `addr_i`  in  32  register address; only `addr_i[3:0]` is decoded
- `we_i`  in  1  write strobe
- `re_i`  in  1  read strobe; needed for the claim side effect
- `irq_src_i`  in  N_SRC  peripheral interrupt lines, active-high, clk domain
- `data_o`  out  32  read data, combinational from addr_i
- `int_req_o`  out  1  interrupt request to core, active-high

## Operation
- Registers (offset: meaning):
  - 0x0 ENABLE: RW, bits [N_SRC-1:0]; upper bits read 0.
  - 0x4 PENDING: RO; writes ignored.
  - 0x8 CLAIM: read returns the winning ID in [4:0]; write with [4:0] = ID signals completion.
  - 0xC MODE: RW, bit i = 1 means edge-triggered, 0 means level-triggered.
  - Other offsets read 0; writes to them are ignored.
- Internal state: `src_q[N_SRC-1:0]` holds the previous sample of irq_src_i. The FSM has two states, IDLE and CLAIMED, and holds `claimed_id[4:0]`.
- Pending set, evaluated each clock edge:
  - Edge mode: set on `irq_src_i[i] & ~src_q[i]`. This happens in any FSM state, so an edge arriving while claimed is queued.
  - Level mode: set when `irq_src_i[i]` = 1, unless the FSM is CLAIMED with claimed_id = i+1 (gateway blocks re-pend while in service).
  - Pending sets regardless of ENABLE. ENABLE only gates arbitration.
- Winner: the lowest i with `pending[i] & enable[i]`. Winner ID = i+1, or 0 if there is none.
- `int_req_o` = (state == IDLE) && (winner ID != 0).
- CLAIM read:
  - `data_o` = winner ID when the state is IDLE, and 0 when it is CLAIMED.
  - Side effect: on an edge where `re_i & ~we_i & addr[3:0] == 0x8`, state is IDLE, and winner != 0:
    - clear pending[winner-1];
    - set claimed_id = winner;
    - move to CLAIMED.
  - A claim read while CLAIMED, or with no winner, returns 0 and has no effect.
- Complete: on an edge where `we_i & addr[3:0] == 0x8`, state is CLAIMED, and `data_i[4:0]` == claimed_id:
  - move to IDLE;
  - clear claimed_id.
  - A mismatched ID, ID 0, or a complete while IDLE is ignored.
- `we_i` takes precedence over `re_i` when both are high in the same cycle.

## Timing
- Reset, on an edge with rst_n = 0:
  - ENABLE, PENDING, MODE, src_q and claimed_id are cleared to 0;
  - the FSM goes to IDLE;
  - `int_req_o` = 0;
  - `data_o` = 0 while rst_n = 0.
- Reset in CLAIMED state forces IDLE and drops all pending bits.
- Source-to-request latency: irq_src_i rises before edge k, pending is set at edge k, and int_req_o goes high after edge k, i.e. one edge.
- Claim to request deassert: int_req_o drops right after the claim edge, regardless of other pending bits.
- Complete to re-request: if other pending-and-enabled bits exist, int_req_o rises right after the complete edge.
- Level source still high at complete: it re-pends at the complete edge + 1, and int_req_o rises after that edge.
- Simultaneous set and clear of the same pending bit, i.e. a claim edge that coincides with a new edge-mode edge on the same source: set wins and the event is not lost.
- Writing ENABLE with bit i = 0 while pending[i] = 1: the bit stays pending and int_req_o drops after that edge if no other winner exists. Re-enabling restores the request.
- MODE change takes effect from the next edge. Existing pending bits are kept.
- Combinational read path only; there are no wait states.

## Test plan
- Reset, then write ENABLE = 0x01 and MODE = 0x01, then pulse irq_src_i[0] for one cycle -> PENDING reads 0x1, int_req_o = 1, and a CLAIM read returns 1. Afterwards PENDING = 0, int_req_o = 0, and a second CLAIM read returns 0.
- ENABLE = 0xFF, raise sources 5 and 2 in the same cycle (edge mode) -> the first claim returns 3. Write CLAIM = 3, then the next claim returns 6. Write CLAIM = 6, then int_req_o = 0.
- Level mode on source 0, held high -> claim returns 1 and int_req_o stays 0 while CLAIMED. Complete with 1 -> int_req_o is 1 again one edge later. Drop the source before complete -> no re-request.
- Complete with the wrong ID: claim ID 1, write CLAIM = 2 -> state stays CLAIMED, int_req_o stays 0, and a claim read returns 0. Then write CLAIM = 1 -> returns to IDLE.
- Edge on source 0 on the same edge as the claim of ID 1 -> PENDING[0] = 1 after the claim. After complete, int_req_o = 1 and the claim returns 1 again.
- Assert rst_n = 0 while CLAIMED with pending 0x0C -> after the reset edge, all registers read 0, int_req_o = 0, and the next claim read returns 0.
